// File: rtl/reg_file.sv
// ============================================================================
// reg_file: 32 x XLEN integer register file, 1 sync write / 2 async read ports.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  output logic [31:0]     wr_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [31:0]     wr_cnt_q;
  logic [31:0]     wr_cnt_d;
  logic            wr_commit;

  // x0 is hardwired, so a write to it is neither stored nor counted.
  assign wr_commit = wr_en_i && (rd_addr_i != '0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      regs_d[rd_addr_i] = rd_data_i;
      wr_cnt_d          = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  logic [XLEN-1:0] rs1_raw;
  logic [XLEN-1:0] rs2_raw;

  always_comb begin
    rs1_raw = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
    rs2_raw = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = wr_commit && !rst;

  always_comb begin
    rs1_data_o = (fwd_ok && (rs1_addr_i == rd_addr_i)) ? rd_data_i : rs1_raw;
    rs2_data_o = (fwd_ok && (rs2_addr_i == rd_addr_i)) ? rd_data_i : rs2_raw;
  end
`else
  always_comb begin
    rs1_data_o = rs1_raw;
    rs2_data_o = rs2_raw;
  end
`endif

  assign wr_cnt_o = wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file: table-driven, scoreboarded self-checking bench for reg_file.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        wr_en_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [31:0] wr_cnt_o;

  reg_file #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .wr_en_i    (wr_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .wr_cnt_o   (wr_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive at negedge, push expectation, compare post-edge state.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    wr_en_i    = v.we;
    rd_addr_i  = v.rd;
    rd_data_i  = v.data;
    rs1_addr_i = v.rs1;
    rs2_addr_i = v.rs2;
    sb.push_back('{d1: v.e1, d2: v.e2, cnt: v.ecnt});
    if (v.we && v.rd != 5'd0) model[v.rd] = v.data;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d_rs1", idx), rs1_data_o, e.d1);
    check($sformatf("vec%0d_rs2", idx), rs2_data_o, e.d2);
    check($sformatf("vec%0d_cnt", idx), wr_cnt_o, e.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [7];
    foreach (model[i]) model[i] = '0;

    rst = 1'b1; wr_en_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rs1", rs1_data_o, 32'h0);
    check("reset_rs2", rs2_data_o, 32'h0);
    check("reset_cnt", wr_cnt_o, 32'h0);

    // Preload x5, then reset with a colliding write to x6.
    @(negedge clk);
    rst = 1'b0;
    vecs[0] = '{we:1'b1, rd:5'd5, data:32'hDEAD_BEEF, rs1:5'd5, rs2:5'd6,
                e1:32'hDEAD_BEEF, e2:32'h0, ecnt:32'd1};
    apply(vecs[0], 0);

    @(negedge clk);
    rst = 1'b1; wr_en_i = 1'b1; rd_addr_i = 5'd6; rd_data_i = 32'h0000_1234;
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd6;
    #1;
    check("prereset_x5", rs1_data_o, 32'hDEAD_BEEF);
    check("prereset_x6_nofwd", rs2_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en_i = 1'b0;
    foreach (model[i]) model[i] = '0;
    #1;
    check("postreset_x5", rs1_data_o, 32'h0);
    check("postreset_x6", rs2_data_o, 32'h0);
    check("postreset_cnt", wr_cnt_o, 32'h0);

    vecs[0] = '{we:1'b1, rd:5'd1,  data:32'hA5A5_A5A5, rs1:5'd1, rs2:5'd31,
                e1:32'hA5A5_A5A5, e2:32'h0, ecnt:32'd1};
    vecs[1] = '{we:1'b1, rd:5'd31, data:32'h0000_0001, rs1:5'd1, rs2:5'd31,
                e1:32'hA5A5_A5A5, e2:32'h1, ecnt:32'd2};
    vecs[2] = '{we:1'b1, rd:5'd0,  data:32'hFFFF_FFFF, rs1:5'd0, rs2:5'd1,
                e1:32'h0, e2:32'hA5A5_A5A5, ecnt:32'd2};
    vecs[3] = '{we:1'b1, rd:5'd7,  data:32'h0000_0011, rs1:5'd7, rs2:5'd0,
                e1:32'h11, e2:32'h0, ecnt:32'd3};
    vecs[4] = '{we:1'b1, rd:5'd9,  data:32'h0000_0055, rs1:5'd9, rs2:5'd9,
                e1:32'h55, e2:32'h55, ecnt:32'd4};
    vecs[5] = '{we:1'b0, rd:5'd9,  data:32'hCAFE_0000, rs1:5'd9, rs2:5'd9,
                e1:32'h55, e2:32'h55, ecnt:32'd4};
    vecs[6] = '{we:1'b1, rd:5'd31, data:32'h8000_0000, rs1:5'd31, rs2:5'd7,
                e1:32'h8000_0000, e2:32'h11, ecnt:32'd5};
    for (int i = 0; i < 7; i++) apply(vecs[i], i + 1);

    // Same-cycle read of the register being written.
    @(negedge clk);
    wr_en_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h22;
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("samecycle_x7", rs1_data_o, 32'h22);
`else
    check("samecycle_x7", rs1_data_o, 32'h11);
`endif
    check("samecycle_x9", rs2_data_o, 32'h55);
    model[7] = 32'h22;
    @(posedge clk);
    #1;
    check("aftercycle_x7", rs1_data_o, 32'h22);
    check("aftercycle_cnt", wr_cnt_o, 32'd6);

    // Hold: random write address/data with wr_en_i low.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wr_en_i   = 1'b0;
      rd_addr_i = 5'($urandom_range(0, 31));
      rd_data_i = $urandom;
    end
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      rs1_addr_i = 5'(2 * r);
      rs2_addr_i = 5'(2 * r + 1);
      #1;
      check($sformatf("hold_x%0d", 2 * r), rs1_data_o, model[2 * r]);
      check($sformatf("hold_x%0d", 2 * r + 1), rs2_data_o, model[2 * r + 1]);
    end
    check("hold_cnt", wr_cnt_o, 32'd6);

    // Counter wrap from a deposited all-ones value.
    @(negedge clk);
    wr_en_i = 1'b0;
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    check("wrap_preload", wr_cnt_o, 32'hFFFF_FFFF);
    vecs[0] = '{we:1'b1, rd:5'd3, data:32'h0000_0033, rs1:5'd3, rs2:5'd0,
                e1:32'h33, e2:32'h0, ecnt:32'd0};
    apply(vecs[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
